tanh_lut_loader: RTL and testbench

TANH_LUT_LOADER -- requirements
Module: tanh_lut_loader

---
 rtl/tanh_lut_loader.sv | 136 +++++++++++++
 tb/tb_tanh_lut_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tanh_lut_loader.sv
// Streams DEPTH sign-magnitude tanh entries into a LUT RAM. Each write comes one cycle after its
// transfer, and s_ready is the only backpressure. Define TANH_LUT_CHECK_EN to enable entry checking on err.
module tanh_lut_loader #(
    parameter int WIDTH     = 12,
    parameter int FRAC_BITS = 6,
    parameter int ADDR_W    = 9,
    parameter int DEPTH     = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [WIDTH-1:0]  s_data,
    output logic              s_ready,
    output logic              lut_we,
    output logic [ADDR_W-1:0] lut_addr,
    output logic [WIDTH-1:0]  lut_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    if (DEPTH > (1 << ADDR_W) || FRAC_BITS >= WIDTH) begin : g_param_chk
        $error("tanh_lut_loader: illegal DEPTH/ADDR_W or FRAC_BITS/WIDTH");
    end

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t            state_q, state_d;
    logic              lut_we_q, lut_we_d;
    logic [ADDR_W-1:0] lut_addr_q, lut_addr_d;
    logic [WIDTH-1:0]  lut_wdata_q, lut_wdata_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic sess_start;
    logic wr_xfer;

    assign sess_start = (state_q == IDLE || state_q == DONE) && start && !abort;
    // A transfer that coincides with abort is accepted on the wire but never written.
    assign wr_xfer    = (state_q == LOAD) && s_valid && !abort;

    always_comb begin
        state_d     = state_q;
        lut_we_d    = 1'b0;
        lut_addr_d  = lut_addr_q;
        lut_wdata_d = lut_wdata_q;
        count_d     = count_q;
        case (state_q)
            IDLE, DONE: begin
                if (sess_start) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (s_valid) begin
                    lut_we_d    = 1'b1;
                    lut_addr_d  = count_q[ADDR_W-1:0];
                    lut_wdata_d = s_data;
                    count_d     = count_q + 1'b1;
                    if (count_q == LAST) state_d = FLUSH;
                end
            end
            FLUSH:   state_d = abort ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lut_we_q    <= 1'b0;
            lut_addr_q  <= '0;
            lut_wdata_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            lut_we_q    <= lut_we_d;
            lut_addr_q  <= lut_addr_d;
            lut_wdata_q <= lut_wdata_d;
            count_q     <= count_d;
        end
    end

`ifdef TANH_LUT_CHECK_EN
    localparam logic [WIDTH-2:0] MAG_ONE = (WIDTH-1)'(1 << FRAC_BITS);

    logic             err_q, err_d;
    logic [WIDTH-2:0] prev_mag_q, prev_mag_d;
    logic [WIDTH-2:0] mag;

    assign mag = s_data[WIDTH-2:0];

    // Entries must be non-negative, at most 1.0, and non-decreasing within a session.
    always_comb begin
        err_d      = err_q;
        prev_mag_d = prev_mag_q;
        if (sess_start) begin
            err_d      = 1'b0;
            prev_mag_d = '0;
        end else if (wr_xfer) begin
            prev_mag_d = mag;
            if (s_data[WIDTH-1] || mag > MAG_ONE || mag < prev_mag_q) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            prev_mag_q <= '0;
        end else begin
            err_q      <= err_d;
            prev_mag_q <= prev_mag_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign s_ready   = (state_q == LOAD);
    assign busy      = (state_q == LOAD) || (state_q == FLUSH);
    assign done      = (state_q == DONE);
    assign lut_we    = lut_we_q;
    assign lut_addr  = lut_addr_q;
    assign lut_wdata = lut_wdata_q;
    assign count     = count_q;

endmodule

// File: tb/tb_tanh_lut_loader.sv
// Directed bench for tanh_lut_loader: full load, gaps, abort, ignored start, entry check, mid-session reset.
module tb_tanh_lut_loader;

    localparam int WIDTH  = 12;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;
`ifdef TANH_LUT_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              s_valid = 1'b0;
    logic [WIDTH-1:0]  s_data = '0;
    logic              s_ready, lut_we, busy, done, err;
    logic [ADDR_W-1:0] lut_addr;
    logic [WIDTH-1:0]  lut_wdata;
    logic [ADDR_W:0]   count;

    int tests = 0;
    int fails = 0;
    int wr_idx = 0;
    logic mon_en = 1'b0;

    tanh_lut_loader #(.WIDTH(WIDTH), .FRAC_BITS(6), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    // Write scoreboard: every accepted, non-aborted transfer must appear as exactly one write
    // in the following cycle at the next sequential address; every other cycle has no write.
    always @(posedge clk) begin
        logic             ev;
        logic [WIDTH-1:0] ed;
        int               ea;
        if (mon_en && !rst) begin
            if (start && !abort && !busy) wr_idx = 0;
            ev = s_valid && s_ready && !abort;
            ed = s_data;
            ea = wr_idx;
            #1;
            if (!rst) begin
                tests++;
                if (lut_we !== ev) begin
                    fails++;
                    $display("FAIL wr_strobe t=%0t lut_we=%b expected=%b", $time, lut_we, ev);
                end else if (ev) begin
                    tests++;
                    if (lut_addr !== ea[ADDR_W-1:0] || lut_wdata !== ed) begin
                        fails++;
                        $display("FAIL wr_payload t=%0t addr=%0d data=%h expected addr=%0d data=%h",
                                 $time, lut_addr, lut_wdata, ea, ed);
                    end
                    wr_idx++;
                end
            end
        end
    end

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk); abort = 1'b1; s_valid = 1'b0;
        @(negedge clk); abort = 1'b0;
    endtask

    // Presents n transfers with data i/div; returns with s_valid low, one edge after the last transfer.
    task automatic send(input int n, input int div, input bit gaps);
        int i = 0;
        int cyc = 0;
        while (i < n && cyc < 4 * n + 20) begin
            @(negedge clk);
            cyc++;
            s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = WIDTH'(i / div);
            if (s_valid && s_ready) i++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        tests++;
        if (i != n) begin
            fails++;
            $display("FAIL send_timeout sent=%0d expected=%0d", i, n);
        end
    endtask

    task automatic test_reset();
        #1;
        tests++; if (s_ready !== 1'b0)  begin fails++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
        tests++; if (lut_we !== 1'b0)   begin fails++; $display("FAIL rst_lut_we got=%b exp=0", lut_we); end
        tests++; if (lut_addr !== '0)   begin fails++; $display("FAIL rst_lut_addr got=%0d exp=0", lut_addr); end
        tests++; if (lut_wdata !== '0)  begin fails++; $display("FAIL rst_lut_wdata got=%h exp=0", lut_wdata); end
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL rst_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0)     begin fails++; $display("FAIL rst_done got=%b exp=0", done); end
        tests++; if (err !== 1'b0)      begin fails++; $display("FAIL rst_err got=%b exp=0", err); end
        tests++; if (count !== '0)      begin fails++; $display("FAIL rst_count got=%0d exp=0", count); end
        @(negedge clk); rst = 1'b0; mon_en = 1'b1;
    endtask

    task automatic test_full_load();
        do_start();
        tests++; if (busy !== 1'b1 || s_ready !== 1'b1) begin
            fails++; $display("FAIL load_entry busy=%b s_ready=%b exp=1,1", busy, s_ready);
        end
        send(DEPTH, 8, 1'b0);
        tests++; if (s_ready !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL flush_state s_ready=%b busy=%b exp=0,1", s_ready, busy);
        end
        repeat (2) @(negedge clk);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL full_done got=%b exp=1", done); end
        tests++; if (busy !== 1'b0 || s_ready !== 1'b0) begin
            fails++; $display("FAIL full_idle busy=%b s_ready=%b exp=0,0", busy, s_ready);
        end
        tests++; if (count !== 10'd512) begin fails++; $display("FAIL full_count got=%0d exp=512", count); end
        tests++; if (wr_idx != DEPTH) begin fails++; $display("FAIL full_writes got=%0d exp=512", wr_idx); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL full_err got=%b exp=0", err); end
        repeat (3) @(negedge clk);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL done_hold got=%b exp=1", done); end
    endtask

    task automatic test_gaps();
        do_start();
        tests++; if (count !== '0 || done !== 1'b0) begin
            fails++; $display("FAIL restart_clear count=%0d done=%b exp=0,0", count, done);
        end
        send(40, 1, 1'b1);
        tests++; if (count !== 10'd40 || busy !== 1'b1) begin
            fails++; $display("FAIL gaps_count count=%0d busy=%b exp=40,1", count, busy);
        end
        do_abort();
    endtask

    task automatic test_abort();
        do_start();
        send(100, 2, 1'b0);
        @(negedge clk); s_valid = 1'b1; s_data = 12'h7ff; abort = 1'b1;
        @(negedge clk); s_valid = 1'b0; abort = 1'b0;
        tests++; if (count !== 10'd100) begin fails++; $display("FAIL abort_count got=%0d exp=100", count); end
        tests++; if (busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b0) begin
            fails++; $display("FAIL abort_idle busy=%b done=%b s_ready=%b exp=0,0,0", busy, done, s_ready);
        end
        tests++; if (wr_idx != 100) begin fails++; $display("FAIL abort_writes got=%0d exp=100", wr_idx); end
    endtask

    task automatic test_start_in_load();
        do_start();
        send(10, 1, 1'b0);
        @(negedge clk); s_valid = 1'b1; s_data = 12'd9; start = 1'b1;
        @(negedge clk); s_valid = 1'b0; start = 1'b0;
        send(5, 1, 1'b0);
        tests++; if (count !== 10'd16) begin fails++; $display("FAIL start_ignored_count got=%0d exp=16", count); end
        tests++; if (wr_idx != 16) begin fails++; $display("FAIL start_ignored_writes got=%0d exp=16", wr_idx); end
        do_abort();
    endtask

    task automatic test_check();
        logic [WIDTH-1:0] vals [3];
        logic             exp_after [3];
        vals[0] = 12'd16; vals[1] = 12'd20; vals[2] = 12'd18;
        exp_after[0] = 1'b0; exp_after[1] = 1'b0; exp_after[2] = ERR_EXP;
        do_start();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); s_valid = 1'b1; s_data = vals[k];
            @(negedge clk); s_valid = 1'b0;
            tests++; if (err !== exp_after[k]) begin
                fails++; $display("FAIL check_mono_%0d got=%b exp=%b", k, err, exp_after[k]);
            end
        end
        repeat (2) @(negedge clk);
        tests++; if (err !== ERR_EXP) begin fails++; $display("FAIL err_sticky got=%b exp=%b", err, ERR_EXP); end
        do_abort();
        do_start();
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clear got=%b exp=0", err); end
        @(negedge clk); s_valid = 1'b1; s_data = 12'h840;
        @(negedge clk); s_valid = 1'b0;
        tests++; if (err !== ERR_EXP) begin fails++; $display("FAIL check_sign got=%b exp=%b", err, ERR_EXP); end
        do_abort();
    endtask

    task automatic test_rst_mid();
        do_start();
        @(negedge clk); s_valid = 1'b1; s_data = 12'h015;
        @(negedge clk); s_valid = 1'b0; rst = 1'b1;
        #1;
        tests++; if (lut_we !== 1'b0 || lut_addr !== '0 || lut_wdata !== '0) begin
            fails++; $display("FAIL rst_mid_write we=%b addr=%0d data=%h exp=0,0,0", lut_we, lut_addr, lut_wdata);
        end
        tests++; if (busy !== 1'b0 || s_ready !== 1'b0 || count !== '0 || done !== 1'b0) begin
            fails++; $display("FAIL rst_mid_state busy=%b s_ready=%b count=%0d done=%b exp=0,0,0,0",
                              busy, s_ready, count, done);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        tests++; if (lut_we !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_mid_after we=%b busy=%b exp=0,0", lut_we, busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_gaps();
        test_abort();
        test_start_in_load();
        test_check();
        test_rst_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
